mem_wb_stage_param: RTL and testbench

Parametrised MEM/WB pipeline stage register with valid tracking, stall/flush control, registered load-data alignment and sign extension, writeback-source selection, and a retired-instruction counter. It sits between the data-memory access stage and the register-file write port. It replaces the plain field-copy MEM/WB latch: its outputs drive the register-file write data, write address and write enable directly.

---
 rtl/mem_wb_stage_param.sv | 112 +++++++++++
 tb/tb_mem_wb_stage_param.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage_param.sv
// rtl/mem_wb_stage_param.sv - MEM/WB stage register with load alignment, writeback select and retire counter
// State captures on the falling clock edge; reset is asynchronous active-low.
module mem_wb_stage_param #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 32
) (
  input  logic               clk_MemWB,
  input  logic               rst_n_MemWB,
  input  logic               en_MemWB,
  input  logic               flush_MemWB,
  input  logic               valid_in_MemWB,
  input  logic [XLEN-1:0]    PC4_in_MemWB,
  input  logic [RADDR_W-1:0] Rd_addr_in_MemWB,
  input  logic [XLEN-1:0]    ALU_in_MemWB,
  input  logic [31:0]        Dmem_data_in_MemWB,
  input  logic [2:0]         funct3_in_MemWB,
  input  logic [1:0]         addr_lo_in_MemWB,
  input  logic [1:0]         MemtoReg_in_MemWB,
  input  logic               RegWrite_in_MemWB,
  output logic               valid_out_MemWB,
  output logic [RADDR_W-1:0] Rd_addr_out_MemWB,
  output logic               RegWrite_out_MemWB,
  output logic [XLEN-1:0]    WB_data_out_MemWB,
  output logic [XLEN-1:0]    PC4_out_MemWB,
  output logic [CNT_W-1:0]   retired_cnt_MemWB
);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;

  logic [7:0]      byte_lane;
  logic [15:0]     half_lane;
  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] wb_next;
  logic            regwrite_next;

  always_comb begin
    byte_lane = Dmem_data_in_MemWB[7:0];
    case (addr_lo_in_MemWB)
      2'd0: byte_lane = Dmem_data_in_MemWB[7:0];
      2'd1: byte_lane = Dmem_data_in_MemWB[15:8];
      2'd2: byte_lane = Dmem_data_in_MemWB[23:16];
      2'd3: byte_lane = Dmem_data_in_MemWB[31:24];
      default: byte_lane = Dmem_data_in_MemWB[7:0];
    endcase
  end

  // Halfword lane ignores addr_lo[0]; misaligned halfwords are not trapped here.
  always_comb begin
    half_lane = addr_lo_in_MemWB[1] ? Dmem_data_in_MemWB[31:16] : Dmem_data_in_MemWB[15:0];
  end

  always_comb begin
    load_val = XLEN'($signed(Dmem_data_in_MemWB));
    case (funct3_in_MemWB)
      F3_LB:   load_val = XLEN'($signed(byte_lane));
      F3_LBU:  load_val = XLEN'(byte_lane);
      F3_LH:   load_val = XLEN'($signed(half_lane));
      F3_LHU:  load_val = XLEN'(half_lane);
      default: load_val = XLEN'($signed(Dmem_data_in_MemWB));
    endcase
  end

  always_comb begin
    wb_next = '0;
    case (MemtoReg_in_MemWB)
      WB_ALU:  wb_next = ALU_in_MemWB;
      WB_LOAD: wb_next = load_val;
      WB_PC4:  wb_next = PC4_in_MemWB;
      default: wb_next = '0;
    endcase
  end

  // x0 is hardwired, so a write to it is suppressed here rather than in the register file.
  always_comb begin
    regwrite_next = RegWrite_in_MemWB & valid_in_MemWB & (|Rd_addr_in_MemWB);
  end

  always_ff @(negedge clk_MemWB or negedge rst_n_MemWB) begin
    if (!rst_n_MemWB) begin
      valid_out_MemWB    <= 1'b0;
      Rd_addr_out_MemWB  <= '0;
      RegWrite_out_MemWB <= 1'b0;
      WB_data_out_MemWB  <= '0;
      PC4_out_MemWB      <= '0;
      retired_cnt_MemWB  <= '0;
    end else if (flush_MemWB) begin
      valid_out_MemWB    <= 1'b0;
      Rd_addr_out_MemWB  <= '0;
      RegWrite_out_MemWB <= 1'b0;
      WB_data_out_MemWB  <= '0;
      PC4_out_MemWB      <= '0;
    end else if (en_MemWB) begin
      valid_out_MemWB    <= valid_in_MemWB;
      Rd_addr_out_MemWB  <= Rd_addr_in_MemWB;
      RegWrite_out_MemWB <= regwrite_next;
      WB_data_out_MemWB  <= wb_next;
      PC4_out_MemWB      <= PC4_in_MemWB;
      if (valid_in_MemWB) begin
        retired_cnt_MemWB <= retired_cnt_MemWB + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage_param.sv
// tb/tb_mem_wb_stage_param.sv - directed and random checks of mem_wb_stage_param against a reference model
// A second instance with a 4-bit counter exercises counter wrap.
module tb_mem_wb_stage_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        flush;
  logic        vin;
  logic [31:0] pc4_in;
  logic [4:0]  rd_in;
  logic [31:0] alu_in;
  logic [31:0] dmem;
  logic [2:0]  f3;
  logic [1:0]  off;
  logic [1:0]  mtr;
  logic        rw_in;

  logic        valid_o, rw_o, valid_s, rw_s;
  logic [4:0]  rd_o, rd_s;
  logic [31:0] wb_o, pc4_o, cnt_o, wb_s, pc4_s;
  logic [3:0]  cnt_s;

  int vectors = 0;
  int ncmp = 0;
  int errs = 0;

  logic        m_valid, m_rw;
  logic [4:0]  m_rd;
  logic [31:0] m_wb, m_pc4;
  longint      m_retired;

  always #5 clk = ~clk;

  mem_wb_stage_param #(.XLEN(32), .RADDR_W(5), .CNT_W(32)) dut (
    .clk_MemWB(clk), .rst_n_MemWB(rst_n), .en_MemWB(en), .flush_MemWB(flush),
    .valid_in_MemWB(vin), .PC4_in_MemWB(pc4_in), .Rd_addr_in_MemWB(rd_in),
    .ALU_in_MemWB(alu_in), .Dmem_data_in_MemWB(dmem), .funct3_in_MemWB(f3),
    .addr_lo_in_MemWB(off), .MemtoReg_in_MemWB(mtr), .RegWrite_in_MemWB(rw_in),
    .valid_out_MemWB(valid_o), .Rd_addr_out_MemWB(rd_o), .RegWrite_out_MemWB(rw_o),
    .WB_data_out_MemWB(wb_o), .PC4_out_MemWB(pc4_o), .retired_cnt_MemWB(cnt_o)
  );

  mem_wb_stage_param #(.XLEN(32), .RADDR_W(5), .CNT_W(4)) dut_small (
    .clk_MemWB(clk), .rst_n_MemWB(rst_n), .en_MemWB(en), .flush_MemWB(flush),
    .valid_in_MemWB(vin), .PC4_in_MemWB(pc4_in), .Rd_addr_in_MemWB(rd_in),
    .ALU_in_MemWB(alu_in), .Dmem_data_in_MemWB(dmem), .funct3_in_MemWB(f3),
    .addr_lo_in_MemWB(off), .MemtoReg_in_MemWB(mtr), .RegWrite_in_MemWB(rw_in),
    .valid_out_MemWB(valid_s), .Rd_addr_out_MemWB(rd_s), .RegWrite_out_MemWB(rw_s),
    .WB_data_out_MemWB(wb_s), .PC4_out_MemWB(pc4_s), .retired_cnt_MemWB(cnt_s)
  );

  // Load result derived from byte/halfword arithmetic on the memory word.
  function automatic logic [31:0] load_ref(input logic [31:0] w, input logic [2:0] fn,
                                           input logic [1:0] o);
    logic [31:0] b, h;
    b = (w >> (8 * o)) & 32'hFF;
    h = (w >> (16 * o[1])) & 32'hFFFF;
    case (fn)
      3'b000:  return (b >= 32'd128) ? b - 32'd256 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("valid", 64'(valid_o), 64'(m_valid));
    chk("rd", 64'(rd_o), 64'(m_rd));
    chk("regwrite", 64'(rw_o), 64'(m_rw));
    chk("wb_data", 64'(wb_o), 64'(m_wb));
    chk("pc4", 64'(pc4_o), 64'(m_pc4));
    chk("retired", 64'(cnt_o), 64'(m_retired % 64'd4294967296));
    chk("retired4", 64'(cnt_s), 64'(m_retired % 64'd16));
    chk("wb_small", 64'(wb_s), 64'(m_wb));
  endtask

  task automatic model_clear();
    m_valid = 0; m_rw = 0; m_rd = 0; m_wb = 0; m_pc4 = 0; m_retired = 0;
  endtask

  // One falling edge: model follows reset > flush > enable > hold, then outputs are sampled on the rising edge.
  task automatic tick();
    logic [31:0] sel;
    @(negedge clk);
    vectors++;
    if (!rst_n) begin
      model_clear();
    end else if (flush) begin
      m_valid = 0; m_rw = 0; m_rd = 0; m_wb = 0; m_pc4 = 0;
    end else if (en) begin
      case (mtr)
        2'b00:   sel = alu_in;
        2'b01:   sel = load_ref(dmem, f3, off);
        2'b10:   sel = pc4_in;
        default: sel = 32'h0;
      endcase
      m_valid = vin;
      m_rd    = rd_in;
      m_rw    = rw_in && vin && (rd_in != 0);
      m_wb    = sel;
      m_pc4   = pc4_in;
      if (vin) m_retired++;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input logic e, input logic fl, input logic v, input logic [31:0] p,
                       input logic [4:0] r, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] fn, input logic [1:0] o, input logic [1:0] m,
                       input logic w);
    en = e; flush = fl; vin = v; pc4_in = p; rd_in = r; alu_in = a; dmem = d;
    f3 = fn; off = o; mtr = m; rw_in = w;
  endtask

  task automatic load_case(input logic [2:0] fn, input logic [1:0] o, input logic [31:0] exp,
                           input string tag);
    drive(1, 0, 1, 32'h100, 5'd7, 32'h0, 32'h80F07F01, fn, o, 2'b01, 1);
    tick();
    chk(tag, 64'(wb_o), 64'(exp));
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1, 0, 1, 32'h4, 5'd1, 32'h55, 32'h0, 3'b010, 2'd0, 2'b00, 1);
    model_clear();
    #2;
    check_all();
    tick();

    // Mid-cycle asynchronous reset after some captures.
    rst_n = 1'b1;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    check_all();
    tick();
    rst_n = 1'b1;

    drive(1, 0, 1, 32'h8, 5'd5, 32'h1234, 32'h0, 3'b010, 2'd0, 2'b00, 1);
    tick();
    chk("first_wb", 64'(wb_o), 64'h1234);
    chk("first_rw", 64'(rw_o), 64'h1);
    chk("first_cnt", 64'(cnt_o), 64'h1);

    load_case(3'b000, 2'd0, 32'h00000001, "lb0");
    load_case(3'b000, 2'd1, 32'h0000007F, "lb1");
    load_case(3'b000, 2'd2, 32'hFFFFFFF0, "lb2");
    load_case(3'b000, 2'd3, 32'hFFFFFF80, "lb3");
    load_case(3'b100, 2'd2, 32'h000000F0, "lbu2");
    load_case(3'b001, 2'd2, 32'hFFFF80F0, "lh2");
    load_case(3'b101, 2'd0, 32'h00007F01, "lhu0");
    load_case(3'b010, 2'd0, 32'h80F07F01, "lw");

    // Stall for three edges with changing inputs, then flush while stalled.
    drive(1, 0, 1, 32'h200, 5'd9, 32'hCAFE, 32'h0, 3'b010, 2'd0, 2'b00, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, $urandom, 5'($urandom), $urandom, $urandom, 3'($urandom), 2'($urandom),
            2'($urandom), 1);
      tick();
      chk("stall_wb", 64'(wb_o), 64'hCAFE);
      chk("stall_rw", 64'(rw_o), 64'h1);
    end
    drive(0, 1, 1, 32'h300, 5'd3, 32'h1, 32'h0, 3'b010, 2'd0, 2'b00, 1);
    tick();
    chk("flush_valid", 64'(valid_o), 64'h0);
    chk("flush_rw", 64'(rw_o), 64'h0);

    drive(1, 0, 1, 32'h10, 5'd0, 32'h77, 32'h0, 3'b010, 2'd0, 2'b00, 1);
    tick();
    chk("rd0_rw", 64'(rw_o), 64'h0);
    drive(1, 0, 0, 32'h14, 5'd6, 32'h78, 32'h0, 3'b010, 2'd0, 2'b00, 1);
    tick();
    chk("inval_rw", 64'(rw_o), 64'h0);
    drive(1, 0, 1, 32'h00000104, 5'd1, 32'h79, 32'h0, 3'b010, 2'd0, 2'b10, 1);
    tick();
    chk("pc4_sel", 64'(wb_o), 64'h104);
    drive(1, 0, 1, 32'h108, 5'd1, 32'h79, 32'h0, 3'b010, 2'd0, 2'b11, 1);
    tick();
    chk("zero_sel", 64'(wb_o), 64'h0);

    // Counter wrap on the 4-bit instance with bubbles interleaved.
    rst_n = 1'b0;
    #1;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      drive(1, 0, 1, 32'(i * 4), 5'd2, 32'(i), 32'h0, 3'b010, 2'd0, 2'b00, 1);
      tick();
      drive(1, (i % 2) == 0, 0, 32'h0, 5'd2, 32'h0, 32'h0, 3'b010, 2'd0, 2'b00, 1);
      tick();
    end
    chk("cnt4_15", 64'(cnt_s), 64'd15);
    drive(1, 0, 1, 32'h40, 5'd2, 32'h0, 32'h0, 3'b010, 2'd0, 2'b00, 1);
    tick();
    chk("cnt4_wrap", 64'(cnt_s), 64'd0);
    chk("cnt32_16", 64'(cnt_o), 64'd16);

    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
            $urandom, ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom), $urandom, $urandom,
            3'($urandom), 2'($urandom), 2'($urandom), 1'($urandom));
      if ($urandom_range(0, 40) == 0) rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
